// File: rtl/dreg_share_pkg.sv
// Shared types and helpers for the shared D-register arbiter.
// Holds the FSM state encoding, a width helper and the round-robin pick.
package dreg_share_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Widest requester vector the round-robin pick handles.
  localparam int MAX_REQ = 8;

  // Bit width needed to index n items, never less than one bit.
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // First asserted request at or after 'start', wrapping modulo n.
  // Returns 0 when nothing is requested; callers gate on |req.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [2:0]         start,
                                         input int                 n);
    logic [2:0] win;
    logic       found;
    int         idx;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = (int'(start) + i) % n;
      if (!found && (i < n) && req[idx[2:0]]) begin
        win   = idx[2:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/dreg_en.sv
// Plain enabled D flip-flop bank with asynchronous active-low reset.
module dreg_en #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  // Load on enable, clear immediately on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   q_q <= '0;
    else if (en_i) q_q <= d_i;
  end

  assign q_o = q_q;

endmodule

// File: rtl/dreg_share_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register among NREQ producers.
// The grant is registered; the granted slice loads into q at the close of
// each GRANT cycle. The owner may lock to keep back-to-back writes.
// Optional: define DREG_SHARE_LOCK_TIMEOUT_EN to cap a locked run at
// MAX_LOCK consecutive grant cycles.
module dreg_share_arbiter
  import dreg_share_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_LOCK = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         lock,
  input  logic [NREQ*WIDTH-1:0]   d,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic [WIDTH-1:0]        q,
  output logic                    q_upd
);

  localparam int IW = clog2w(NREQ);

  state_e            state_q, state_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     ptr_q, ptr_d;     // next search start
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              upd_q;
  logic [IW-1:0]     pick;
  logic [IW-1:0]     pick_nxt;
  logic              any_req;
  logic              hold;
  logic              expire;
  logic              load_en;
  logic [WIDTH-1:0]  d_sel;

  assign any_req  = |req;
  assign pick     = IW'(rr_pick(8'(req), 3'(ptr_q), NREQ));
  assign pick_nxt = (pick == IW'(NREQ-1)) ? '0 : pick + 1'b1;

`ifdef DREG_SHARE_LOCK_TIMEOUT_EN
  localparam int CW = clog2w(MAX_LOCK + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // The current GRANT cycle is the MAX_LOCK-th of this owner's run.
  assign expire = (cnt_q == CW'(MAX_LOCK - 1));

  // Count consecutive held grant cycles; any fresh arbitration or IDLE clears.
  always_comb begin
    cnt_d = '0;
    if ((state_q == GRANT) && hold) cnt_d = cnt_q + 1'b1;
  end

  // Lock run counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_max_lock;
  assign unused_max_lock = (MAX_LOCK > 0);
  assign expire = 1'b0;
`endif

  // Owner keeps the register only while it both locks and requests.
  assign hold = lock[owner_q] & req[owner_q] & ~expire;

  // State, grant and pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      upd_q   <= load_en;
    end
  end

  // Next-state: arbitrate from IDLE or straight out of GRANT (no bubble).
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          owner_d = pick;
          ptr_d   = pick_nxt;
          gnt_d   = NREQ'(1) << pick;
        end
      end
      GRANT: begin
        if (hold) begin
          gnt_d = gnt_q;
        end else if (any_req) begin
          owner_d = pick;
          ptr_d   = pick_nxt;
          gnt_d   = NREQ'(1) << pick;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: every GRANT cycle commits the owner's slice, even if req dropped.
  always_comb begin
    load_en = (state_q == GRANT);
    d_sel   = d[int'(owner_q)*WIDTH +: WIDTH];
  end

  dreg_en #(.WIDTH(WIDTH)) u_q (
    .clk_i  (clk),
    .rst_ni (reset),
    .en_i   (load_en),
    .d_i    (d_sel),
    .q_o    (q)
  );

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign q_upd = upd_q;

endmodule

// File: tb/tb_dreg_share_arbiter.sv
// Self-checking bench for dreg_share_arbiter: directed scenarios followed by
// random traffic, all compared against a cycle-level reference model.
module tb_dreg_share_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int ML = 8;

  logic             clk;
  logic             reset;
  logic [N-1:0]     req;
  logic [N-1:0]     lock;
  logic [N*W-1:0]   d;
  logic [N-1:0]     gnt;
  logic [1:0]       owner;
  logic [W-1:0]     q;
  logic             q_upd;

  int n_chk;
  int n_pass;

  // reference model state
  int m_g;      // current grantee, -1 when idle
  int m_start;  // next search start
  int m_owner;
  int m_q;
  int m_upd;
  int m_run;    // grant cycles in current held run

  dreg_share_arbiter #(.NREQ(N), .WIDTH(W), .MAX_LOCK(ML)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .lock  (lock),
    .d     (d),
    .gnt   (gnt),
    .owner (owner),
    .q     (q),
    .q_upd (q_upd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  task automatic m_reset();
    m_g = -1; m_start = 0; m_owner = 0; m_q = 0; m_upd = 0; m_run = 0;
  endtask

  // One clock of the model, using the inputs that the next rising edge sees.
  task automatic m_step();
    bit hold;
    int w;
    m_upd = (m_g >= 0) ? 1 : 0;
    if (m_g >= 0) m_q = int'(d[m_g*W +: W]);
    hold = (m_g >= 0) && lock[m_g] && req[m_g];
`ifdef DREG_SHARE_LOCK_TIMEOUT_EN
    if (m_run >= ML) hold = 0;
`endif
    if (hold) begin
      m_run++;
    end else if (req != 0) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_start + k) % N;
        if (w < 0 && req[idx]) w = idx;
      end
      m_g = w; m_owner = w; m_start = (w + 1) % N; m_run = 1;
    end else begin
      m_g = -1; m_run = 0;
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] eg;
    eg = (m_g < 0) ? '0 : (N'(1) << m_g);
    chk("gnt",   32'(gnt),   32'(eg));
    chk("owner", 32'(owner), 32'(m_owner));
    chk("q",     32'(q),     32'(m_q));
    chk("q_upd", 32'(q_upd), 32'(m_upd));
  endtask

  // Check outputs from the previous edge, then present new inputs.
  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] l, input logic [N*W-1:0] dv);
    @(negedge clk);
    compare_all();
    req = r; lock = l; d = dv;
    m_step();
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    m_reset();
    reset = 1'b0; req = 4'b1111; lock = '0; d = 32'h1122_3344;

    // reset held with all requests asserted: nothing may be granted
    repeat (3) begin
      @(negedge clk);
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_q",   32'(q),   32'h0);
      chk("rst_upd", 32'(q_upd), 32'h0);
    end
    req = '0; reset = 1'b1;

    // full round robin, then first grant after reset must be requester 0
    drive(4'b1111, 4'b0000, 32'h4433_2211);
    @(negedge clk);
    chk("first_gnt", 32'(gnt), 32'h1);
    compare_all();
    m_step();
    repeat (5) drive(4'b1111, 4'b0000, $urandom);
    repeat (2) drive(4'b0000, 4'b0000, $urandom);

    // single request, slice 2 = A5
    drive(4'b0100, 4'b0000, 32'h00A5_0000);
    drive(4'b0000, 4'b0000, 32'h00A5_0000);
    @(negedge clk);
    chk("single_q", 32'(q), 32'hA5);
    chk("single_upd", 32'(q_upd), 32'h1);
    compare_all();
    req = '0; m_step();
    drive(4'b0000, 4'b0000, '0);

    // lock: requester 1 keeps lock+req while requester 3 waits
    drive(4'b0010, 4'b0010, $urandom);
    repeat (5) drive(4'b1010, 4'b0010, $urandom);
    drive(4'b1000, 4'b0000, $urandom);
    // lock from a non-owner is ignored
    drive(4'b1001, 4'b0001, $urandom);
    repeat (2) drive(4'b0000, 4'b0000, $urandom);

    // owner drops req during its grant cycle: load still happens
    drive(4'b0001, 4'b0000, 32'h0000_0011);
    drive(4'b0000, 4'b0000, 32'h0000_0077);
    drive(4'b0000, 4'b0000, '0);
    drive(4'b0000, 4'b0000, '0);

    // random traffic with occasional locks
    for (int i = 0; i < 300; i++) begin
      logic [N-1:0] r, l;
      r = N'($urandom);
      l = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      drive(r, l, $urandom);
    end
    repeat (3) drive(4'b0000, 4'b0000, '0);

    // reset in the middle of a grant to requester 0 with d = FF
    drive(4'b0001, 4'b0000, 32'hFFFF_FFFF);
    @(negedge clk);
    compare_all();
    #2 reset = 1'b0;
    #1;
    chk("midrst_gnt", 32'(gnt), 32'h0);
    chk("midrst_q",   32'(q),   32'h0);
    @(negedge clk);
    chk("midrst_q_hold", 32'(q), 32'h0);
    chk("midrst_upd",    32'(q_upd), 32'h0);
    req = '0; reset = 1'b1;
    m_reset();
    drive(4'b0010, 4'b0000, 32'h0000_5A00);
    repeat (3) drive(4'b0000, 4'b0000, '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/dreg_share_arbiter.md
Name: dreg_share_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit D-register among NREQ requesters.
- Each requester presents data plus a request. The arbiter grants one requester at a time and loads that requester's data into the shared register.
- Supports a lock that holds ownership across consecutive writes.
- Sits between producer blocks and the shared state register; the register is a plain enabled D flip-flop bank.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, shared register width
- MAX_LOCK, 8, max consecutive locked grant cycles (used only with LOCK_TIMEOUT_EN)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous active-low reset (0 = reset)
- req  input  NREQ  per-requester write request, level
- lock  input  NREQ  per-requester lock; honoured only for the current owner
- d  input  NREQ*WIDTH  packed data; slice i = d[i*WIDTH +: WIDTH]
- gnt  output  NREQ  one-hot grant, registered
- owner  output  $clog2(NREQ)  index of current/last grantee
- q  output  WIDTH  shared register contents
- q_upd  output  1  one-cycle pulse the cycle after q changes

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - gnt=0, owner=0, q=0, q_upd=0
  - state=IDLE, rr pointer=0, lock counter=0
- States:
  - IDLE: gnt=0.
  - GRANT: gnt one-hot at owner; at the closing edge, q<=d[owner slice].
- Arbitration:
  - Search starts at index (last owner+1) mod NREQ, wrapping; the first asserted req wins.
  - After reset the search starts at index 0.
  - gnt is registered: req high in cycle n (IDLE) -> gnt in cycle n+1 -> q valid in n+2 with q_upd=1 in n+2.
- GRANT exit conditions, evaluated each GRANT cycle:
  - lock[owner]&&req[owner]: stay GRANT, same owner, load again next edge (back-to-back writes, one per cycle).
  - Otherwise, if any other req (or req[owner]) is asserted: re-arbitrate from owner+1 and move directly to GRANT for the winner next cycle. No idle bubble. Requester owner is searched last.
  - Otherwise go to IDLE; q holds its value.
- Loading of q:
  - req dropped by the owner during its GRANT cycle: the load still occurs (the grant is committed once issued).
  - q never changes in IDLE; exactly one slice loads per GRANT cycle.
- lock from a non-owner is ignored; lock without req is ignored.
- Simultaneous requests: no starvation. Any requester with req held continuously is granted within NREQ grant cycles when nobody locks.
- Reset mid-GRANT: the pending load is discarded, q=0, and gnt drops immediately.
- owner holds its last value in IDLE.

Optional Feature:
- Macro: DREG_SHARE_LOCK_TIMEOUT_EN.
- Defined:
  - A counter tracks consecutive GRANT cycles of one owner.
  - When it reaches MAX_LOCK, lock is ignored for one arbitration and the grant passes to the next requester if one is asserted.
  - The counter clears on owner change or IDLE.
- Undefined: lock is held indefinitely; no counter is instantiated.

Decomposition:
- Package dreg_share_pkg holds:
  - state enum {IDLE, GRANT}
  - function for round-robin pick (req vector, start index) -> index
  - log2 width constant helper
- Sub-module dreg_en: WIDTH-bit D-register with enable and asynchronous active-low reset, used for q.
- The arbiter FSM and pointer stay in the top.

Test Plan:
- Reset: reset=0 while req=4'b1111 -> gnt=0, q=0, q_upd=0 throughout. Release -> first gnt=4'b0001.
- Single request: req=4'b0100, d slice2=8'hA5 at cycle 0 -> gnt=4'b0100 at cycle 1, q=8'hA5 and q_upd=1 at cycle 2, back to IDLE.
- Round robin: req=4'b1111 held -> gnt sequence 0001,0010,0100,1000,0001 on consecutive cycles, no gaps.
- Lock: owner 1 holds lock+req for 5 cycles while req[3]=1 -> gnt=4'b0010 for 5 cycles, then 4'b1000. With DREG_SHARE_LOCK_TIMEOUT_EN and MAX_LOCK=3, the handover occurs after 3 cycles.
- Reset mid-GRANT: assert reset during gnt=4'b0001 with d=8'hFF -> q stays 0, gnt=0 asynchronously.
- Dropped request: owner drops req in its GRANT cycle -> q still loads its slice, state returns to IDLE.
